// File: rtl/i2c_cmd_snoop_rst.sv
// ---------------------------------------------------------------------------
// i2c_cmd_snoop_rst
//
// Passive I2C bus monitor that turns write commands into per-channel resets.
// It only listens to SCL/SDA and never drives the bus, so it can sit beside
// the real I2C/UFM slave. It follows write transactions to DEV_ADDR made of
// a channel byte followed by an opcode byte:
//   - STOP_CODE (or, with STRICT=1, any unknown opcode) pulls the selected
//     channel's reset low at once.
//   - RUN_CODE arms a release that takes effect on the next I2C STOP.
// A repeated START, a STOP arriving too early, or an SCL timeout all drop a
// pending release. Resets that are already asserted are never undone by an
// aborted transaction.
//
// Ports:
//   clk_i       - system clock
//   resetn_i    - asynchronous active-low reset
//   scl_i       - raw I2C SCL (asynchronous to clk_i)
//   sda_i       - raw I2C SDA (asynchronous to clk_i)
//   rstn_o      - per-channel active-low reset, NUM_CH bits
//   cmd_valid_o - one-clock pulse when a recognised opcode byte completes
//   cmd_ch_o    - channel index of the last recognised command
//   cmd_op_o    - opcode byte of the last recognised command
//   timeout_o   - one-clock pulse when a stalled transaction is aborted
// ---------------------------------------------------------------------------
module i2c_cmd_snoop_rst #(
  parameter logic [6:0] DEV_ADDR    = 7'h40,
  parameter int         NUM_CH      = 4,
  parameter logic [7:0] RUN_CODE    = 8'hFF,
  parameter logic [7:0] STOP_CODE   = 8'hE0,
  parameter bit         STRICT      = 1'b1,
  parameter int         SYNC_DEPTH  = 3,
  parameter int         TIMEOUT_CYC = 65535
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic [NUM_CH-1:0] rstn_o,
  output logic              cmd_valid_o,
  output logic [3:0]        cmd_ch_o,
  output logic [7:0]        cmd_op_o,
  output logic              timeout_o
);

  // Channel bound and timeout terminal value, sized to match the registers
  // they are compared against.
  localparam logic [7:0]  LP_NUM_CH  = 8'(NUM_CH);
  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  LP_WR_ADDR = {DEV_ADDR, 1'b0};

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_CHAN,
    ST_CHAN_ACK,
    ST_OPC,
    ST_OPC_ACK,
    ST_ARMED,
    ST_WAIT_STOP
  } state_t;

  // -------------------------------------------------------------------------
  // Register and next-value declarations
  // -------------------------------------------------------------------------
  logic [SYNC_DEPTH-1:0] r_sclSync;
  logic [SYNC_DEPTH-1:0] r_sdaSync;

  state_t            r_state;
  state_t            w_state;
  logic [2:0]        r_bitCnt;
  logic [2:0]        w_bitCnt;
  logic [7:0]        r_shift;
  logic [7:0]        w_shift;
  logic [3:0]        r_chan;
  logic [3:0]        w_chan;
  logic              r_startPend;
  logic              w_startPend;
  logic [NUM_CH-1:0] r_rstn;
  logic [NUM_CH-1:0] w_rstn;
  logic              r_cmdValid;
  logic              w_cmdValid;
  logic [3:0]        r_cmdCh;
  logic [3:0]        w_cmdCh;
  logic [7:0]        r_cmdOp;
  logic [7:0]        w_cmdOp;
  logic              r_timeout;
  logic              w_timeout;
  logic [15:0]       r_toCnt;
  logic [15:0]       w_toCnt;

  logic w_sclCur;
  logic w_sclPrev;
  logic w_sdaCur;
  logic w_sdaPrev;
  logic w_sclRise;
  logic w_sclFall;
  logic w_startCond;
  logic w_stopCond;
  logic w_sclEdge;
  logic w_isRun;
  logic w_isStop;

  // -------------------------------------------------------------------------
  // Bring SCL and SDA into the clock domain. The flops reset to 1 so an idle
  // (pulled-up) bus never looks like an edge when reset is released.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_sclSync <= '1;
      r_sdaSync <= '1;
    end else begin
      r_sclSync <= {r_sclSync[SYNC_DEPTH-2:0], scl_i};
      r_sdaSync <= {r_sdaSync[SYNC_DEPTH-2:0], sda_i};
    end
  end

  // Edges are judged between the last two synchronizer stages. START and
  // STOP require SCL to be high in both stages so an SDA change that races
  // an SCL edge is not mistaken for a bus condition.
  assign w_sclCur    = r_sclSync[SYNC_DEPTH-2];
  assign w_sclPrev   = r_sclSync[SYNC_DEPTH-1];
  assign w_sdaCur    = r_sdaSync[SYNC_DEPTH-2];
  assign w_sdaPrev   = r_sdaSync[SYNC_DEPTH-1];
  assign w_sclRise   = ~w_sclPrev &  w_sclCur;
  assign w_sclFall   =  w_sclPrev & ~w_sclCur;
  assign w_sclEdge   = w_sclRise | w_sclFall;
  assign w_startCond =  w_sdaPrev & ~w_sdaCur & w_sclPrev & w_sclCur;
  assign w_stopCond  = ~w_sdaPrev &  w_sdaCur & w_sclPrev & w_sclCur;

  // Opcode classification of the byte currently held in the shift register.
  assign w_isRun  = (r_shift == RUN_CODE);
  assign w_isStop = (r_shift == STOP_CODE);

  // -------------------------------------------------------------------------
  // Next-state and datapath logic.
  // Bus conditions take priority in this order: STOP, START, timeout, then
  // ordinary SCL edges. r_startPend marks "a START has been seen, the next
  // SCL fall begins the address byte"; while it is set, no data is shifted.
  // A release is only ever pending while the FSM sits in ST_ARMED, so every
  // path that leaves ST_ARMED without a STOP implicitly discards the arm.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state     = r_state;
    w_bitCnt    = r_bitCnt;
    w_shift     = r_shift;
    w_chan      = r_chan;
    w_startPend = r_startPend;
    w_rstn      = r_rstn;
    w_cmdValid  = 1'b0;
    w_cmdCh     = r_cmdCh;
    w_cmdOp     = r_cmdOp;
    w_timeout   = 1'b0;
    w_toCnt     = r_toCnt;

    // Inactivity counter: cleared by any SCL edge and whenever idle.
    if ((r_state == ST_IDLE) || w_sclEdge) begin
      w_toCnt = '0;
    end else begin
      w_toCnt = r_toCnt + 16'd1;
    end

    if (w_stopCond) begin
      if (r_state == ST_ARMED) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (r_chan == 4'(i)) begin
            w_rstn[i] = 1'b1;
          end
        end
      end
      w_state     = ST_IDLE;
      w_startPend = 1'b0;
      w_bitCnt    = '0;
    end else if (w_startCond) begin
      w_startPend = 1'b1;
      w_bitCnt    = '0;
      if (r_state != ST_IDLE) begin
        w_state = ST_ADDR;
      end
    end else if ((r_state != ST_IDLE) && !w_sclEdge && (r_toCnt == LP_TO_LAST)) begin
      w_timeout   = 1'b1;
      w_state     = ST_IDLE;
      w_startPend = 1'b0;
      w_bitCnt    = '0;
      w_toCnt     = '0;
    end else if (r_startPend) begin
      if (w_sclFall) begin
        w_startPend = 1'b0;
        w_state     = ST_ADDR;
        w_bitCnt    = '0;
      end
    end else begin
      unique case (r_state)
        ST_ADDR, ST_CHAN, ST_OPC: begin
          if (w_sclRise) begin
            w_shift = {r_shift[6:0], w_sdaCur};
          end else if (w_sclFall) begin
            if (r_bitCnt != 3'd7) begin
              w_bitCnt = r_bitCnt + 3'd1;
            end else begin
              // Eighth falling edge: the full byte is in r_shift.
              w_bitCnt = '0;
              if (r_state == ST_ADDR) begin
                w_state = (r_shift == LP_WR_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
              end else if (r_state == ST_CHAN) begin
                if (r_shift < LP_NUM_CH) begin
                  w_chan  = r_shift[3:0];
                  w_state = ST_CHAN_ACK;
                end else begin
                  w_state = ST_WAIT_STOP;
                end
              end else begin
                if (w_isRun) begin
                  w_cmdValid = 1'b1;
                  w_cmdCh    = r_chan;
                  w_cmdOp    = r_shift;
                  w_state    = ST_OPC_ACK;
                end else if (w_isStop || STRICT) begin
                  w_cmdValid = 1'b1;
                  w_cmdCh    = r_chan;
                  w_cmdOp    = r_shift;
                  for (int i = 0; i < NUM_CH; i++) begin
                    if (r_chan == 4'(i)) begin
                      w_rstn[i] = 1'b0;
                    end
                  end
                  w_state = ST_WAIT_STOP;
                end else begin
                  w_state = ST_WAIT_STOP;
                end
              end
            end
          end
        end

        // A NACK on the ninth rising edge ends our interest immediately; a
        // fall still in an ACK state therefore means the byte was ACKed.
        ST_ADDR_ACK, ST_CHAN_ACK, ST_OPC_ACK: begin
          if (w_sclRise && w_sdaCur) begin
            w_state = ST_WAIT_STOP;
          end else if (w_sclFall) begin
            w_bitCnt = '0;
            if (r_state == ST_ADDR_ACK) begin
              w_state = ST_CHAN;
            end else if (r_state == ST_CHAN_ACK) begin
              w_state = ST_OPC;
            end else begin
              w_state = ST_ARMED;
            end
          end
        end

        ST_IDLE, ST_ARMED, ST_WAIT_STOP: begin
          w_state = r_state;
        end

        default: begin
          w_state = ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM state register.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers. Resets default to released (all ones) so
  // a system reset of this monitor never holds the channels in reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_chan      <= '0;
      r_startPend <= 1'b0;
      r_rstn      <= '1;
      r_cmdValid  <= 1'b0;
      r_cmdCh     <= '0;
      r_cmdOp     <= '0;
      r_timeout   <= 1'b0;
      r_toCnt     <= '0;
    end else begin
      r_bitCnt    <= w_bitCnt;
      r_shift     <= w_shift;
      r_chan      <= w_chan;
      r_startPend <= w_startPend;
      r_rstn      <= w_rstn;
      r_cmdValid  <= w_cmdValid;
      r_cmdCh     <= w_cmdCh;
      r_cmdOp     <= w_cmdOp;
      r_timeout   <= w_timeout;
      r_toCnt     <= w_toCnt;
    end
  end

  assign rstn_o      = r_rstn;
  assign cmd_valid_o = r_cmdValid;
  assign cmd_ch_o    = r_cmdCh;
  assign cmd_op_o    = r_cmdOp;
  assign timeout_o   = r_timeout;

endmodule
